// File: rtl/exu_pkg.sv
// Shared constants and types for the execute stage.
// Optional multiplier is enabled by defining EXU_MUL_EN.
package exu_pkg;

    localparam int unsigned EXU_XLEN  = 32;
    localparam int unsigned EXU_RIDX  = 5;
    // One shift-add step per operand bit yields the low XLEN product bits.
    localparam int unsigned MUL_ITERS = EXU_XLEN;

    typedef enum logic [3:0] {
        OpAdd   = 4'd0,
        OpSub   = 4'd1,
        OpAnd   = 4'd2,
        OpOr    = 4'd3,
        OpXor   = 4'd4,
        OpSlt   = 4'd5,
        OpSltu  = 4'd6,
        OpSll   = 4'd7,
        OpSrl   = 4'd8,
        OpSra   = 4'd9,
        OpPassb = 4'd10,
        OpMul   = 4'd11
    } op_e;

    typedef enum logic {
        StIdle = 1'b0,
        StMul  = 1'b1
    } state_e;

endpackage

// File: rtl/exu_mul_iter.sv
// Iterative shift-add multiplier: one partial-product step per clock while run is high.
// done is combinational and marks the edge on which the final step is taken;
// product carries the value being committed on that edge.
module exu_mul_iter
    import exu_pkg::*;
#(
    parameter int unsigned XLEN  = EXU_XLEN,
    parameter int unsigned ITERS = MUL_ITERS
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic            run,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] product
);

    localparam int unsigned CntW = $clog2(ITERS);

    logic [XLEN-1:0] a_q, b_q, acc_q, acc_d;
    logic [CntW-1:0] cnt_q;

    // Next accumulator value and completion detect for the current step.
    always_comb begin
        acc_d   = acc_q + (b_q[0] ? a_q : '0);
        done    = run && (cnt_q == CntW'(ITERS - 1));
        product = acc_d;
    end

    // Operand shift registers, accumulator and iteration counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
        end else if (flush) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (start) begin
            a_q   <= a;
            b_q   <= b;
            acc_q <= '0;
            cnt_q <= '0;
        end else if (run) begin
            acc_q <= acc_d;
            a_q   <= a_q << 1;
            b_q   <= b_q >> 1;
            cnt_q <= done ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/exu_stage.sv
// Execute stage: single-cycle ALU plus optional iterative multiplier, with
// registered write-back toward the register file.
// Define EXU_MUL_EN to implement MUL; otherwise MUL decodes as illegal.
module exu_stage
    import exu_pkg::*;
#(
    parameter int unsigned XLEN    = EXU_XLEN,
    parameter int unsigned RIDX    = EXU_RIDX,
    parameter bit          ZERO_R0 = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [3:0]      i_op,
    input  logic [XLEN-1:0] i_rs0_val,
    input  logic [XLEN-1:0] i_rs1_val,
    input  logic [XLEN-1:0] i_imm,
    input  logic            i_use_imm,
    input  logic [RIDX-1:0] i_rd,
    input  logic            i_flush,
    output logic            o_wb_we,
    output logic [RIDX-1:0] o_wb_reg,
    output logic [XLEN-1:0] o_wb_val,
    output logic            o_busy,
    output logic            o_illegal
);

    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_res;
    logic [4:0]      shamt;
    logic            op_legal;
    logic            op_is_mul;
    logic            accept;
    logic            rd_is_zero;

    logic            wb_we_q;
    logic [RIDX-1:0] wb_reg_q;
    logic [XLEN-1:0] wb_val_q;
    logic            illegal_q;

    assign op_b       = i_use_imm ? i_imm : i_rs1_val;
    assign shamt      = op_b[4:0];
    // A flush in the same cycle drops the request entirely.
    assign accept     = i_valid && o_ready && !i_flush;
    assign rd_is_zero = ZERO_R0 && (i_rd == '0);

    // Opcode decode and single-cycle ALU result.
    always_comb begin
        alu_res   = '0;
        op_legal  = 1'b1;
        op_is_mul = 1'b0;
        case (i_op)
            OpAdd:   alu_res = i_rs0_val + op_b;
            OpSub:   alu_res = i_rs0_val - op_b;
            OpAnd:   alu_res = i_rs0_val & op_b;
            OpOr:    alu_res = i_rs0_val | op_b;
            OpXor:   alu_res = i_rs0_val ^ op_b;
            OpSlt:   alu_res[0] = $signed(i_rs0_val) < $signed(op_b);
            OpSltu:  alu_res[0] = i_rs0_val < op_b;
            OpSll:   alu_res = i_rs0_val << shamt;
            OpSrl:   alu_res = i_rs0_val >> shamt;
            OpSra:   alu_res = $signed(i_rs0_val) >>> shamt;
            OpPassb: alu_res = op_b;
`ifdef EXU_MUL_EN
            OpMul:   op_is_mul = 1'b1;
`endif
            default: op_legal = 1'b0;
        endcase
    end

`ifdef EXU_MUL_EN
    state_e          state_q, state_d;
    logic [RIDX-1:0] rd_q;
    logic            mul_start;
    logic            mul_done;
    logic            mul_commit;
    logic [XLEN-1:0] mul_product;

    assign mul_start  = accept && op_is_mul;
    // Flush wins over completion on the final iteration edge.
    assign mul_commit = mul_done && !i_flush && !(ZERO_R0 && (rd_q == '0));
    assign o_ready    = (state_q == StIdle);
    assign o_busy     = (state_q == StMul);

    exu_mul_iter #(
        .XLEN  (XLEN),
        .ITERS (MUL_ITERS)
    ) u_mul (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .start   (mul_start),
        .flush   (i_flush),
        .run     (o_busy),
        .a       (i_rs0_val),
        .b       (op_b),
        .done    (mul_done),
        .product (mul_product)
    );

    // FSM next state: leave MUL on flush or completion.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (mul_start) state_d = StMul;
            StMul:   if (i_flush || mul_done) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM state register and latched multiply destination.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            if (mul_start) rd_q <= i_rd;
        end
    end
`else
    assign o_ready = 1'b1;
    assign o_busy  = 1'b0;
`endif

    // Write-back and illegal-op pulses; index/value hold between commits.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wb_we_q   <= 1'b0;
            wb_reg_q  <= '0;
            wb_val_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            wb_we_q   <= 1'b0;
            illegal_q <= 1'b0;
            if (accept) begin
                if (!op_legal) begin
                    illegal_q <= 1'b1;
                end else if (!op_is_mul && !rd_is_zero) begin
                    wb_we_q  <= 1'b1;
                    wb_reg_q <= i_rd;
                    wb_val_q <= alu_res;
                end
            end
`ifdef EXU_MUL_EN
            if (mul_commit) begin
                wb_we_q  <= 1'b1;
                wb_reg_q <= rd_q;
                wb_val_q <= mul_product;
            end
`endif
        end
    end

    assign o_wb_we   = wb_we_q;
    assign o_wb_reg  = wb_reg_q;
    assign o_wb_val  = wb_val_q;
    assign o_illegal = illegal_q;

endmodule

// File: tb/tb_exu_stage.sv
// Directed self-checking bench for exu_stage (MUL scenarios only with EXU_MUL_EN).
module tb_exu_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid;
    logic        ready;
    logic [3:0]  op;
    logic [31:0] rs0, rs1, imm;
    logic        use_imm;
    logic [4:0]  rd;
    logic        flush;
    logic        wb_we;
    logic [4:0]  wb_reg;
    logic [31:0] wb_val;
    logic        busy;
    logic        illegal;

    int checks = 0;
    int passes = 0;
    logic [4:0]  last_reg;
    logic [31:0] last_val;

    always #5 clk = ~clk;

    exu_stage dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_valid   (valid),
        .o_ready   (ready),
        .i_op      (op),
        .i_rs0_val (rs0),
        .i_rs1_val (rs1),
        .i_imm     (imm),
        .i_use_imm (use_imm),
        .i_rd      (rd),
        .i_flush   (flush),
        .o_wb_we   (wb_we),
        .o_wb_reg  (wb_reg),
        .o_wb_val  (wb_val),
        .o_busy    (busy),
        .o_illegal (illegal)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] im, input logic ui, input logic [4:0] d);
        valid = 1'b1; op = o; rs0 = a; rs1 = b; imm = im; use_imm = ui; rd = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; valid = 1'b0; op = '0; rs0 = '0; rs1 = '0; imm = '0;
        use_imm = 1'b0; rd = '0; flush = 1'b0;
        #1;
        checks++;
        if ({ready, wb_we, wb_reg, wb_val, busy, illegal} !== {1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0})
            $display("FAIL reset: got rdy=%b we=%b reg=%0d val=%h busy=%b ill=%b want 1 0 0 0 0 0",
                     ready, wb_we, wb_reg, wb_val, busy, illegal);
        else passes++;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_add();
        drive(4'd0, 32'h5, 32'h7, 32'h0, 1'b0, 5'd3);
        tick();
        valid = 1'b0;
        checks++;
        if ({wb_we, wb_reg, wb_val} !== {1'b1, 5'd3, 32'h0000_000C})
            $display("FAIL add: got we=%b reg=%0d val=%h want 1 3 0000000c", wb_we, wb_reg, wb_val);
        else passes++;
        tick();
        checks++;
        if ({wb_we, wb_reg, wb_val} !== {1'b0, 5'd3, 32'h0000_000C})
            $display("FAIL add_hold: got we=%b reg=%0d val=%h want 0 3 0000000c",
                     wb_we, wb_reg, wb_val);
        else passes++;
        last_reg = 5'd3; last_val = 32'hC;
    endtask

    task automatic test_back_to_back();
        drive(4'd1, 32'h0, 32'h1, 32'h0, 1'b0, 5'd1);
        tick();
        checks++;
        if ({wb_we, wb_reg, wb_val} !== {1'b1, 5'd1, 32'hFFFF_FFFF})
            $display("FAIL b2b_sub: got we=%b reg=%0d val=%h want 1 1 ffffffff", wb_we, wb_reg, wb_val);
        else passes++;
        drive(4'd9, 32'h8000_0000, 32'h55, 32'h4, 1'b1, 5'd2);
        tick();
        valid = 1'b0;
        checks++;
        if ({wb_we, wb_reg, wb_val} !== {1'b1, 5'd2, 32'hF800_0000})
            $display("FAIL b2b_sra: got we=%b reg=%0d val=%h want 1 2 f8000000", wb_we, wb_reg, wb_val);
        else passes++;
        last_reg = 5'd2; last_val = 32'hF800_0000;
    endtask

    task automatic test_alu_ops();
        logic [3:0]  ops [9] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd10, 4'd0};
        logic [31:0] av  [9] = '{32'hF0F0_00FF, 32'hF0F0_00FF, 32'hF0F0_00FF, 32'hFFFF_FFFF,
                                 32'hFFFF_FFFF, 32'h1, 32'h8000_0000, 32'h1234_5678,
                                 32'hFFFF_FFFF};
        logic [31:0] bv  [9] = '{32'h0FF0_0F0F, 32'h0FF0_0F0F, 32'h0FF0_0F0F, 32'h1, 32'h1,
                                 32'h23, 32'h1F, 32'hDEAD_BEEF, 32'h2};
        logic [31:0] ev  [9] = '{32'h00F0_000F, 32'hFFF0_0FFF, 32'hFF00_0FF0, 32'h1, 32'h0,
                                 32'h8, 32'h1, 32'hDEAD_BEEF, 32'h1};
        for (int i = 0; i < 9; i++) begin
            drive(ops[i], av[i], bv[i], 32'h0, 1'b0, 5'(i + 10));
            tick();
            checks++;
            if ({wb_we, wb_reg, wb_val} !== {1'b1, 5'(i + 10), ev[i]})
                $display("FAIL alu_op%0d: got we=%b reg=%0d val=%h want 1 %0d %h",
                         ops[i], wb_we, wb_reg, wb_val, i + 10, ev[i]);
            else passes++;
        end
        valid = 1'b0;
        last_reg = 5'd18; last_val = 32'h1;
        tick();
    endtask

    task automatic test_zero_r0();
        drive(4'd0, 32'h11, 32'h22, 32'h0, 1'b0, 5'd0);
        tick();
        valid = 1'b0;
        checks++;
        if ({wb_we, wb_reg, wb_val} !== {1'b0, last_reg, last_val})
            $display("FAIL zero_r0: got we=%b reg=%0d val=%h want 0 %0d %h",
                     wb_we, wb_reg, wb_val, last_reg, last_val);
        else passes++;
    endtask

    task automatic test_illegal();
        drive(4'hF, 32'h1, 32'h2, 32'h0, 1'b0, 5'd4);
        tick();
        valid = 1'b0;
        checks++;
        if ({illegal, wb_we, wb_reg, wb_val} !== {1'b1, 1'b0, last_reg, last_val})
            $display("FAIL illegal_f: got ill=%b we=%b reg=%0d val=%h want 1 0 %0d %h",
                     illegal, wb_we, wb_reg, wb_val, last_reg, last_val);
        else passes++;
        tick();
        checks++;
        if (illegal !== 1'b0)
            $display("FAIL illegal_pulse: got ill=%b want 0", illegal);
        else passes++;
        drive(4'hC, 32'h1, 32'h2, 32'h0, 1'b0, 5'd4);
        tick();
        valid = 1'b0;
        checks++;
        if ({illegal, wb_we} !== 2'b10)
            $display("FAIL illegal_c: got ill=%b we=%b want 1 0", illegal, wb_we);
        else passes++;
    endtask

    task automatic test_flush_idle();
        drive(4'd0, 32'h100, 32'h200, 32'h0, 1'b0, 5'd6);
        flush = 1'b1;
        tick();
        valid = 1'b0; flush = 1'b0;
        checks++;
        if ({wb_we, wb_reg, wb_val} !== {1'b0, last_reg, last_val})
            $display("FAIL flush_idle: got we=%b reg=%0d val=%h want 0 %0d %h",
                     wb_we, wb_reg, wb_val, last_reg, last_val);
        else passes++;
    endtask

`ifdef EXU_MUL_EN
    task automatic test_mul();
        int busy_cycles = 0;
        drive(4'd11, 32'h0001_0003, 32'h0000_0010, 32'h0, 1'b0, 5'd7);
        tick();
        // Present a competing ADD with different operands while busy.
        drive(4'd0, 32'h40, 32'h2, 32'h0, 1'b0, 5'd9);
        if (ready === 1'b0) busy_cycles++;
        for (int k = 1; k < 32; k++) begin
            tick();
            if (ready === 1'b0 && wb_we === 1'b0) busy_cycles++;
        end
        checks++;
        if (busy_cycles != 32)
            $display("FAIL mul_busy: got %0d busy cycles want 32", busy_cycles);
        else passes++;
        tick();
        checks++;
        if ({wb_we, wb_reg, wb_val, ready} !== {1'b1, 5'd7, 32'h0010_0030, 1'b1})
            $display("FAIL mul_result: got we=%b reg=%0d val=%h rdy=%b want 1 7 00100030 1",
                     wb_we, wb_reg, wb_val, ready);
        else passes++;
        tick();
        valid = 1'b0;
        checks++;
        if ({wb_we, wb_reg, wb_val} !== {1'b1, 5'd9, 32'h42})
            $display("FAIL mul_then_add: got we=%b reg=%0d val=%h want 1 9 00000042",
                     wb_we, wb_reg, wb_val);
        else passes++;
        last_reg = 5'd9; last_val = 32'h42;
    endtask

    task automatic test_mul_flush();
        drive(4'd11, 32'h3, 32'h5, 32'h0, 1'b0, 5'd8);
        tick();
        valid = 1'b0;
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if ({wb_we, ready, busy, wb_reg, wb_val} !== {1'b0, 1'b1, 1'b0, last_reg, last_val})
            $display("FAIL mul_flush: got we=%b rdy=%b busy=%b reg=%0d val=%h want 0 1 0 %0d %h",
                     wb_we, ready, busy, wb_reg, wb_val, last_reg, last_val);
        else passes++;
        repeat (30) tick();
        checks++;
        if (wb_we !== 1'b0)
            $display("FAIL mul_flush_late: got we=%b want 0", wb_we);
        else passes++;
    endtask
`else
    task automatic test_mul_disabled();
        drive(4'd11, 32'h3, 32'h5, 32'h0, 1'b0, 5'd8);
        tick();
        valid = 1'b0;
        checks++;
        if ({illegal, wb_we, ready, busy} !== 4'b1010)
            $display("FAIL mul_disabled: got ill=%b we=%b rdy=%b busy=%b want 1 0 1 0",
                     illegal, wb_we, ready, busy);
        else passes++;
    endtask
`endif

    task automatic test_reset_mid_op();
        drive(4'd11, 32'h7, 32'h9, 32'h0, 1'b0, 5'd5);
        tick();
        valid = 1'b0;
        repeat (4) tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({ready, wb_we, wb_reg, wb_val, busy, illegal} !== {1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0})
            $display("FAIL reset_mid: got rdy=%b we=%b reg=%0d val=%h busy=%b ill=%b want 1 0 0 0 0 0",
                     ready, wb_we, wb_reg, wb_val, busy, illegal);
        else passes++;
        tick();
        rst_n = 1'b1;
        tick();
        drive(4'd0, 32'h10, 32'h20, 32'h0, 1'b0, 5'd12);
        tick();
        valid = 1'b0;
        checks++;
        if ({wb_we, wb_reg, wb_val} !== {1'b1, 5'd12, 32'h30})
            $display("FAIL reset_then_add: got we=%b reg=%0d val=%h want 1 12 00000030",
                     wb_we, wb_reg, wb_val);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_alu_ops();
        test_zero_r0();
        test_illegal();
        test_flush_idle();
`ifdef EXU_MUL_EN
        test_mul();
        test_mul_flush();
`else
        test_mul_disabled();
`endif
        test_reset_mid_op();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/exu_stage.md
Name: exu_stage

Overview:
- Execute stage directly downstream of the register file: consumes the two read-port values plus decoded op/immediate/destination, computes the result, and drives the register-file write-back index and value.
- Single-cycle ALU ops plus an iterative 32-cycle multiplier.
- valid/ready handshake toward decode; one-cycle write-enable pulse toward the register file.

Parameters:
- XLEN, 32, datapath width (operands, immediate, result).
- RIDX, 5, register index width.
- ZERO_R0, 1, when 1 a write-back to index 0 is suppressed (o_wb_we stays 0).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_valid  in  1  decode presents an operation.
- o_ready  out  1  stage can accept; handshake occurs on an edge where i_valid&&o_ready.
- i_op  in  4  opcode (encodings in exu_pkg).
- i_rs0_val  in  XLEN  operand A (register-file read port 0).
- i_rs1_val  in  XLEN  operand B (register-file read port 1).
- i_imm  in  XLEN  immediate.
- i_use_imm  in  1  1: operand B = i_imm.
- i_rd  in  RIDX  destination index.
- i_flush  in  1  synchronous cancel of in-flight work.
- o_wb_we  out  1  write-back valid, one-cycle pulse.
- o_wb_reg  out  RIDX  write-back index.
- o_wb_val  out  XLEN  write-back value.
- o_busy  out  1  multiply in progress.
- o_illegal  out  1  one-cycle pulse on an accepted undefined opcode.

Behaviour:
- Reset (async assert, sync release): state IDLE; o_ready=1; o_wb_we=0; o_wb_reg=0; o_wb_val=0; o_busy=0; o_illegal=0; iteration counter=0.
- Ops: ADD, SUB, AND, OR, XOR, SLT (signed), SLTU, SLL, SRL, SRA (shift amount B[4:0]), PASSB, MUL (low XLEN bits of A*B); other codes are illegal.
- All arithmetic wraps modulo 2^XLEN. SLT/SLTU produce 0 or 1, zero-extended.
- Single-cycle op accepted at edge E0: o_wb_we=1, o_wb_reg=i_rd, o_wb_val=result in the cycle after E0. Back-to-back acceptance every cycle.
- FSM states:
  - IDLE: o_ready=1. Accepting MUL -> MUL.
  - MUL: o_ready=0, o_busy=1. One shift-add iteration per edge E1..E32. At E32: o_wb_we=1 with the product, -> IDLE. MUL latency is 33 cycles.
- Operands and destination are latched at acceptance; later input changes are ignored.
- Idle/hold: o_wb_we=0; o_wb_reg/o_wb_val hold the last committed pair, so an enable-less register file rewrites identical data.
- i_rd=0 with ZERO_R0=1: result is computed, o_wb_we stays 0, o_wb_reg/o_wb_val unchanged.
- Illegal op: o_illegal=1 for one cycle, o_wb_we=0, state stays IDLE.
- i_flush:
  - In MUL: return to IDLE at the next edge, no write-back, counter cleared.
  - In IDLE together with i_valid: the request is dropped, nothing is written.
  - Flush has priority over completion at E32.
- Reset mid-MUL: immediate return to the reset state; the partial product is discarded.

Optional Feature:
- EXU_MUL_EN defined: MUL implemented as above.
- Not defined: MUL is decoded as illegal (o_illegal pulse, no write-back). FSM reduced to IDLE only; o_busy tied 0; o_ready tied 1.

Decomposition:
- exu_pkg: op enum (ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, SLTU=6, SLL=7, SRL=8, SRA=9, PASSB=10, MUL=11), XLEN/RIDX constants, MUL iteration count.
- Sub-module exu_mul_iter: iterative shift-add multiplier with start/flush/done.
  - Instantiated only under EXU_MUL_EN.
  - Top holds the FSM, handshake and write-back registers.

Test Plan:
- Reset then ADD A=0x0000_0005, B=0x0000_0007, rd=3 -> next cycle o_wb_we=1, o_wb_reg=3, o_wb_val=0x0000_000C; then o_wb_we=0, outputs held.
- SUB A=0, B=1 then SRA A=0x8000_0000 imm=4 (use_imm=1), back-to-back -> 0xFFFF_FFFF then 0xF800_0000 on consecutive cycles.
- MUL A=0x0001_0003, B=0x0000_0010, rd=7 -> o_ready=0 for 32 cycles, o_wb_we at cycle 33 with 0x0010_0030; a request presented during busy is not accepted until o_ready returns to 1.
- MUL then i_flush at cycle 10 -> no o_wb_we; o_ready=1 next cycle; o_wb_reg/o_wb_val unchanged.
- ADD rd=0 (ZERO_R0=1) -> o_wb_we=0. Opcode 0xF -> o_illegal one-cycle pulse, no write-back.
- Deassert i_rst_n mid-MUL -> all outputs at reset values immediately; ADD after release works normally.
